// File: rtl/m_7seg_scan.sv
// Time-multiplexed 7-segment digit scanner with a double-buffered display register.
// Optional leading-zero blanking when LZB_EN is defined; outputs are registered, one digit per DIV-cycle slot.
module m_7seg_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 16
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  w_we,
  input  logic [4*DIGITS-1:0]   w_din,
  output logic [3:0]            r_dig,
  output logic [DIGITS-1:0]     r_an,
  output logic                  r_blank,
  output logic                  r_frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_RST  = ~DIGITS'(1);

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_shadow;
  logic [4*DIGITS-1:0] r_disp;

  logic                w_tick;
  logic                w_bound;
  logic [IW-1:0]       w_idx_nxt;
  logic [4*DIGITS-1:0] w_disp_nxt;
  logic [3:0]          w_sel;
  logic [DIGITS-1:0]   w_onehot;
  logic                w_blank_nxt;

  // Outputs are computed from next-state values so slot 0 of a new frame
  // already shows the freshly loaded display register.
  always_comb begin
    w_tick     = (r_cnt == CNT_MAX);
    w_bound    = w_tick && (r_idx == IDX_MAX);
    w_idx_nxt  = r_idx;
    if (w_tick) begin
      w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end
    w_disp_nxt = w_bound ? r_shadow : r_disp;
    w_sel      = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_onehot   = DIGITS'(1) << w_idx_nxt;
  end

`ifdef LZB_EN
  logic [DIGITS-1:0] w_lz;

  // w_lz[i]: digits DIGITS-1 down to i are all zero
  always_comb begin
    w_lz             = '0;
    w_lz[DIGITS-1]   = (w_disp_nxt[4*DIGITS-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      w_lz[i] = w_lz[i+1] && (w_disp_nxt[4*i +: 4] == 4'd0);
    end
    w_blank_nxt = (w_idx_nxt != '0) && w_lz[w_idx_nxt];
  end
`else
  always_comb begin
    w_blank_nxt = 1'b0;
  end
`endif

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_disp   <= '0;
      r_dig    <= 4'd0;
      r_an     <= AN_RST;
      r_blank  <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      r_idx   <= w_idx_nxt;
      r_disp  <= w_disp_nxt;
      if (w_we) begin
        r_shadow <= w_din;
      end
      r_dig   <= w_blank_nxt ? 4'd0 : w_sel;
      r_an    <= w_blank_nxt ? '1 : ~w_onehot;
      r_blank <= w_blank_nxt;
      r_frame <= w_bound;
    end
  end

endmodule

// File: tb/tb_m_7seg_scan.sv
// Scoreboard bench for m_7seg_scan (DIGITS=4, DIV=4); one expected entry per clock cycle.
module tb_m_7seg_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_we  = 1'b0;
  logic [15:0] w_din = 16'h0;
  logic [3:0]  r_dig;
  logic [3:0]  r_an;
  logic        r_blank;
  logic        r_frame;

  typedef struct packed {
    logic [3:0] dig;
    logic [3:0] an;
    logic       blank;
    logic       frame;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   mon_n    = 0;
  int   cyc      = 0;
  int   frames64 = 0;
  bit   cnt_en   = 1'b0;

  m_7seg_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .w_we    (w_we),
    .w_din   (w_din),
    .r_dig   (r_dig),
    .r_an    (r_an),
    .r_blank (r_blank),
    .r_frame (r_frame)
  );

  always #5 w_clk = ~w_clk;

  // Monitor: one expected entry per falling edge while the scoreboard holds any
  initial begin
    forever begin
      @(negedge w_clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        checks++;
        if ({r_dig, r_an, r_blank, r_frame} !== mon_e) begin
          errors++;
          $display("FAIL slot_out #%0d: got dig=%h an=%b blank=%b frame=%b, want dig=%h an=%b blank=%b frame=%b",
                   mon_n, r_dig, r_an, r_blank, r_frame, mon_e.dig, mon_e.an, mon_e.blank, mon_e.frame);
        end
        mon_n++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic push_ent(input logic [3:0] d, input logic [3:0] an, input logic b,
                          input logic f, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.dig   = d;
      e.an    = an;
      e.blank = b;
      e.frame = (k == 0) ? f : 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input logic pulse);
    logic [3:0] d;
    logic [3:0] an;
    logic       bl;
    for (int i = 0; i < DIGITS; i++) begin
      d  = v[4*i +: 4];
      bl = 1'b0;
`ifdef LZB_EN
      bl = (i > 0) && ((v >> (4*i)) == 16'h0);
`endif
      an = bl ? 4'b1111 : ~(4'b0001 << i);
      if (bl) d = 4'h0;
      push_ent(d, an, bl, (i == 0) ? pulse : 1'b0, DIV);
    end
  endtask

  task automatic tick_to(input int k);
    while (cyc < k) begin
      @(posedge w_clk);
      #1;
      cyc++;
      if (cnt_en && cyc <= 64 && r_frame) frames64++;
    end
  endtask

  task automatic write_at(input int k, input logic [15:0] v);
    tick_to(k - 1);
    w_we  = 1'b1;
    w_din = v;
    tick_to(k);
    w_we  = 1'b0;
  endtask

  task automatic release_rst();
    @(posedge w_clk);
    #1;
    w_rst = 1'b0;
    cyc   = 0;
  endtask

  task automatic drain(input string nm);
    int b;
    b = 0;
    while (q.size() > 0 && b < 300) begin
      @(posedge w_clk);
      #1;
      cyc++;
      b++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_%s: %0d expected entries never consumed, want 0", nm, q.size());
      q.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge w_clk);

    // Segment A: scan order, first write, frame spacing, boundary write, last write wins
    release_rst();
    cnt_en = 1'b1;
    push_frame(16'h0000, 1'b0);
    push_frame(16'h1234, 1'b1);
    push_frame(16'hAAAA, 1'b1);
    push_frame(16'hAAAA, 1'b1);
    push_frame(16'h5555, 1'b1);
    push_frame(16'h00F7, 1'b1);
    write_at(5,  16'h1234);
    write_at(20, 16'hAAAA);
    write_at(48, 16'h5555);
    write_at(66, 16'h9999);
    write_at(70, 16'h00F7);
    drain("A");
    cnt_en = 1'b0;
    checks++;
    if (frames64 != 4) begin
      errors++;
      $display("FAIL frame_count_64: got %0d pulses, want 4", frames64);
    end

    // Segment B: asynchronous reset mid-frame at idx 2 discards everything
    w_rst = 1'b1;
    tick_to(cyc + 2);
    release_rst();
    push_frame(16'h0000, 1'b0);
    push_ent(4'h4, 4'b1110, 1'b0, 1'b1, 4);
    push_ent(4'h3, 4'b1101, 1'b0, 1'b0, 4);
    push_ent(4'h2, 4'b1011, 1'b0, 1'b0, 2);
    push_ent(4'h0, 4'b1110, 1'b0, 1'b0, 2);
    push_frame(16'h0000, 1'b0);
    push_frame(16'h0000, 1'b1);
    write_at(3, 16'h1234);
    tick_to(26);
    w_rst = 1'b1;
    tick_to(28);
    w_rst = 1'b0;
    cyc   = 0;
    drain("B");

    // Segment C: leading-zero patterns
    w_rst = 1'b1;
    tick_to(cyc + 2);
    release_rst();
    push_frame(16'h0000, 1'b0);
`ifdef LZB_EN
    push_ent(4'h0, 4'b1110, 1'b0, 1'b1, 4);
    push_ent(4'h5, 4'b1101, 1'b0, 1'b0, 4);
    push_ent(4'h0, 4'b1111, 1'b1, 1'b0, 4);
    push_ent(4'h0, 4'b1111, 1'b1, 1'b0, 4);
`else
    push_ent(4'h0, 4'b1110, 1'b0, 1'b1, 4);
    push_ent(4'h5, 4'b1101, 1'b0, 1'b0, 4);
    push_ent(4'h0, 4'b1011, 1'b0, 1'b0, 4);
    push_ent(4'h0, 4'b0111, 1'b0, 1'b0, 4);
`endif
    push_frame(16'h0000, 1'b1);
    write_at(2,  16'h0050);
    write_at(20, 16'h0000);
    drain("C");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
